// File: rtl/msdap_pkg.sv
// Shared types, coefficient-field positions and helpers for the MSDAP POT ALU family.
package msdap_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OUT  = 2'd2
  } alu_state_e;

  localparam int DEF_DATA_W   = 16;
  localparam int DEF_GUARD_W  = 8;
  localparam int DEF_ACC_W    = 40;
  localparam int DEF_DLY_W    = 8;
  localparam int DEF_RJ_W     = 8;
  localparam int DEF_NUM_RJ   = 16;
  localparam int DEF_NUM_COEF = 512;
  localparam int DEF_NUM_CH   = 2;

  // Coefficient word layout: {sign, delay[DLY_W-1:0]}
  localparam int SIGN_BIT = DEF_DLY_W;
  localparam int DLY_LSB  = 0;
  localparam int ASR_MAX_W = 64;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Arithmetic shift right by one of the low w bits of a, whatever lies above bit w-1.
  function automatic logic [ASR_MAX_W-1:0] asr1(input logic [ASR_MAX_W-1:0] a, input int w);
    logic [ASR_MAX_W-1:0] r;
    r        = a >> 1;
    r[w-1]   = a[w-1];
    return r;
  endfunction

endpackage

// File: rtl/msdap_mc_alu_if.sv
// Start / memory-read / result bus of the multi-channel POT ALU.
interface msdap_mc_alu_if import msdap_pkg::*; #(
    parameter int DATA_W   = 16,
    parameter int GUARD_W  = 8,
    parameter int DLY_W    = 8,
    parameter int RJ_W     = 8,
    parameter int NUM_RJ   = 16,
    parameter int NUM_COEF = 512,
    parameter int NUM_CH   = 2
) ();
    localparam int ACC_W = 2*DATA_W + GUARD_W;
    localparam int CH_W  = idx_w(NUM_CH);
    localparam int RJI_W = idx_w(NUM_RJ);
    localparam int CI_W  = idx_w(NUM_COEF);

    logic                    flush;
    logic                    start;
    logic                    start_ready;
    logic [DLY_W-1:0]        sample_ptr;
    logic [CH_W+RJI_W-1:0]   rj_addr;
    logic [RJ_W-1:0]         rj_data;
    logic [CH_W+CI_W-1:0]    coeff_addr;
    logic [DLY_W:0]          coeff_data;
    logic [CH_W+DLY_W-1:0]   data_addr;
    logic [DATA_W-1:0]       data;
    logic                    out_valid;
    logic                    out_ready;
    logic [CH_W-1:0]         out_ch;
    logic [ACC_W-1:0]        result;
    logic                    coef_ovf;

    modport slave (
        input  flush, start, sample_ptr, rj_data, coeff_data, data, out_ready,
        output start_ready, rj_addr, coeff_addr, data_addr, out_valid, out_ch, result, coef_ovf
    );

    modport master (
        output flush, start, sample_ptr, rj_data, coeff_data, data, out_ready,
        input  start_ready, rj_addr, coeff_addr, data_addr, out_valid, out_ch, result, coef_ovf
    );
endinterface

// File: rtl/msdap_addsub.sv
// Combinational add/subtract of a sign-extended narrow operand into a wider accumulator field.
module msdap_addsub #(
    parameter int A_W = 24,
    parameter int B_W = 16
) (
    input  logic signed [A_W-1:0] a_i,
    input  logic signed [B_W-1:0] b_i,
    input  logic                  sub_i,
    output logic signed [A_W-1:0] y_o
);
    logic signed [A_W-1:0] b_ext;

    assign b_ext = A_W'(b_i);
    assign y_o   = sub_i ? (a_i - b_ext) : (a_i + b_ext);
endmodule

// File: rtl/msdap_mc_alu.sv
// Multi-channel sum-of-powers-of-two ALU: one coefficient step per cycle, one result per channel.
module msdap_mc_alu import msdap_pkg::*; #(
    parameter int DATA_W   = 16,
    parameter int GUARD_W  = 8,
    parameter int ACC_W    = 40,
    parameter int DLY_W    = 8,
    parameter int RJ_W     = 8,
    parameter int NUM_RJ   = 16,
    parameter int NUM_COEF = 512,
    parameter int NUM_CH   = 2
) (
    input  logic            clk,
    input  logic            clear_n,
    msdap_mc_alu_if.slave   bus
);
    localparam int UP_W   = DATA_W + GUARD_W;
    localparam int CH_W   = idx_w(NUM_CH);
    localparam int RJI_W  = idx_w(NUM_RJ);
    localparam int CI_W   = idx_w(NUM_COEF);
    localparam int FILL_W = DLY_W + 1;

    if (ACC_W != 2*DATA_W + GUARD_W) begin : g_bad_acc_w
        $error("ACC_W must equal 2*DATA_W+GUARD_W");
    end

    alu_state_e               state_q, state_d;
    logic [CH_W-1:0]          ch_q, ch_d;
    logic [RJI_W-1:0]         rj_idx_q, rj_idx_d;
    logic [CI_W-1:0]          coef_idx_q, coef_idx_d;
    logic [RJ_W-1:0]          u_cnt_q, u_cnt_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [DLY_W-1:0]         ptr_q, ptr_d;
    logic [FILL_W-1:0]        n_q, n_d, fill_q, fill_d;
    logic                     wrap_q, wrap_d, ovf_q, ovf_d;
    logic signed [ACC_W-1:0]  result_q, result_d;
    logic [CH_W-1:0]          out_ch_q, out_ch_d;
    logic                     coef_ovf_q, coef_ovf_d;

    logic [DLY_W-1:0]         k;
    logic                     sub;
    logic                     pad;
    logic signed [DATA_W-1:0] opnd;
    logic signed [UP_W-1:0]   upper_sum;
    logic signed [ACC_W-1:0]  acc_step, acc_shift_in, acc_shift;
    logic                     grp_empty, grp_last, last_rj, running;
    logic [FILL_W-1:0]        fill_sel;
    logic [DLY_W-1:0]         rd_ofs;

    assign k    = bus.coeff_data[DLY_W-1:0];
    assign sub  = bus.coeff_data[DLY_W];
    // Samples older than the number received so far read as zero.
    assign pad  = {1'b0, k} > n_q;
    assign opnd = pad ? '0 : bus.data;

    msdap_addsub #(.A_W(UP_W), .B_W(DATA_W)) u_addsub (
        .a_i   (acc_q[ACC_W-1:DATA_W]),
        .b_i   (opnd),
        .sub_i (sub),
        .y_o   (upper_sum)
    );

    assign acc_step     = {upper_sum, acc_q[DATA_W-1:0]};
    assign grp_empty    = (bus.rj_data == '0);
    assign grp_last     = grp_empty || ((u_cnt_q + RJ_W'(1)) == bus.rj_data);
    assign last_rj      = (rj_idx_q == RJI_W'(NUM_RJ-1));
    assign acc_shift_in = grp_empty ? acc_q : acc_step;
    assign acc_shift    = ACC_W'(asr1(ASR_MAX_W'(acc_shift_in), ACC_W));
    assign fill_sel     = bus.flush ? '0 : fill_q;

    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        rj_idx_d   = rj_idx_q;
        coef_idx_d = coef_idx_q;
        u_cnt_d    = u_cnt_q;
        acc_d      = acc_q;
        ptr_d      = ptr_q;
        n_d        = n_q;
        fill_d     = fill_q;
        wrap_d     = wrap_q;
        ovf_d      = ovf_q;
        result_d   = result_q;
        out_ch_d   = out_ch_q;
        coef_ovf_d = coef_ovf_q;

        case (state_q)
            IDLE: begin
                fill_d = fill_sel;
                if (bus.start) begin
                    ptr_d      = bus.sample_ptr;
                    n_d        = fill_sel;
                    fill_d     = (fill_sel == FILL_W'(1 << DLY_W)) ? fill_sel : fill_sel + FILL_W'(1);
                    ch_d       = '0;
                    rj_idx_d   = '0;
                    coef_idx_d = '0;
                    u_cnt_d    = '0;
                    acc_d      = '0;
                    wrap_d     = 1'b0;
                    ovf_d      = 1'b0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                if (!grp_empty) begin
                    coef_idx_d = coef_idx_q + CI_W'(1);
                    if (coef_idx_q == '1) wrap_d = 1'b1;
                    // Consuming a slot after the index wrapped means Rj overran the table.
                    if (wrap_q) ovf_d = 1'b1;
                end
                if (grp_last) begin
                    acc_d    = acc_shift;
                    rj_idx_d = rj_idx_q + RJI_W'(1);
                    u_cnt_d  = '0;
                    if (last_rj) begin
                        result_d   = acc_shift;
                        out_ch_d   = ch_q;
                        coef_ovf_d = ovf_d;
                        state_d    = OUT;
                    end
                end else begin
                    acc_d   = acc_step;
                    u_cnt_d = u_cnt_q + RJ_W'(1);
                end
            end
            OUT: begin
                if (bus.out_ready) begin
                    rj_idx_d   = '0;
                    coef_idx_d = '0;
                    u_cnt_d    = '0;
                    acc_d      = '0;
                    wrap_d     = 1'b0;
                    ovf_d      = 1'b0;
                    if (ch_q == CH_W'(NUM_CH-1)) begin
                        ch_d    = '0;
                        state_d = IDLE;
                    end else begin
                        ch_d    = ch_q + CH_W'(1);
                        state_d = RUN;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q    <= IDLE;
            ch_q       <= '0;
            rj_idx_q   <= '0;
            coef_idx_q <= '0;
            u_cnt_q    <= '0;
            acc_q      <= '0;
            ptr_q      <= '0;
            n_q        <= '0;
            fill_q     <= '0;
            wrap_q     <= 1'b0;
            ovf_q      <= 1'b0;
            result_q   <= '0;
            out_ch_q   <= '0;
            coef_ovf_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            rj_idx_q   <= rj_idx_d;
            coef_idx_q <= coef_idx_d;
            u_cnt_q    <= u_cnt_d;
            acc_q      <= acc_d;
            ptr_q      <= ptr_d;
            n_q        <= n_d;
            fill_q     <= fill_d;
            wrap_q     <= wrap_d;
            ovf_q      <= ovf_d;
            result_q   <= result_d;
            out_ch_q   <= out_ch_d;
            coef_ovf_q <= coef_ovf_d;
        end
    end

    assign running         = (state_q == RUN);
    assign rd_ofs          = ptr_q - k;
    assign bus.rj_addr     = running ? {ch_q, rj_idx_q}   : '0;
    assign bus.coeff_addr  = running ? {ch_q, coef_idx_q} : '0;
    assign bus.data_addr   = running ? {ch_q, rd_ofs}     : '0;
    assign bus.start_ready = (state_q == IDLE);
    assign bus.out_valid   = (state_q == OUT);
    assign bus.result      = result_q;
    assign bus.out_ch      = out_ch_q;
    assign bus.coef_ovf    = coef_ovf_q;
endmodule

// File: tb/tb_msdap_mc_alu.sv
// Directed bench for msdap_mc_alu with an arithmetic reference model and a per-cycle scoreboard.
module tb_msdap_mc_alu;
    import msdap_pkg::*;

    typedef struct {
        logic [39:0] res;
        int          ch;
        bit          ovf;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic clear_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   fill_m = 0;

    logic [7:0]  rj_mem   [0:31];
    logic [8:0]  coef_mem [0:1023];
    logic [15:0] dmem     [0:511];
    exp_t        exp_q[$];
    logic [39:0] got_res [2];
    bit          got_ovf [2];

    msdap_mc_alu_if bus ();

    msdap_mc_alu dut (
        .clk     (clk),
        .clear_n (clear_n),
        .bus     (bus)
    );

    assign bus.rj_data    = rj_mem[bus.rj_addr];
    assign bus.coeff_data = coef_mem[bus.coeff_addr];
    assign bus.data       = dmem[bus.data_addr];

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Whole-accumulator arithmetic: adding term*2^16 modulo 2^40, halving after each group.
    function automatic exp_t model(input int c, input int ptr, input int n);
        exp_t        e;
        longint      acc;
        longint      term;
        int          idx, lat, r, k;
        logic [8:0]  cw;
        acc = 0; idx = 0; lat = 0;
        for (int j = 0; j < 16; j++) begin
            r = int'(rj_mem[c*16 + j]);
            lat += (r == 0) ? 1 : r;
            for (int u = 0; u < r; u++) begin
                cw   = coef_mem[c*512 + (idx % 512)];
                k    = int'(cw[7:0]);
                term = 0;
                if (k <= n) term = longint'($signed(dmem[c*256 + ((ptr - k) & 255)]));
                acc  = cw[8] ? (acc - term*65536) : (acc + term*65536);
                acc  = (acc <<< 24) >>> 24;
                idx++;
            end
            acc = acc >>> 1;
        end
        e.res = acc[39:0];
        e.ch  = c;
        e.ovf = (idx > 512);
        e.lat = lat;
        return e;
    endfunction

    task automatic clear_cfg();
        for (int i = 0; i < 32; i++)   rj_mem[i]   = '0;
        for (int i = 0; i < 1024; i++) coef_mem[i] = '0;
        for (int i = 0; i < 512; i++)  dmem[i]     = '0;
    endtask

    task automatic run_sample(input int ptr, input bit do_flush, input int stall, input bit noise);
        int n, t;
        t = 0;
        while (!bus.start_ready && t < 50) begin @(posedge clk); #2; t++; end
        if (!bus.start_ready) begin
            checks++; failures++;
            $display("FAIL start_ready_timeout actual=0 expected=1");
            return;
        end
        bus.sample_ptr = ptr[7:0];
        bus.start      = 1'b1;
        bus.flush      = do_flush;
        if (do_flush) fill_m = 0;
        n = fill_m;
        if (fill_m < 256) fill_m++;
        for (int c = 0; c < 2; c++) exp_q.push_back(model(c, ptr, n));
        @(posedge clk); #2;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        if (noise) begin
            @(posedge clk); #2;
            bus.start = 1'b1; bus.flush = 1'b1; bus.sample_ptr = 8'hAA;
            @(posedge clk); #2;
            bus.start = 1'b0; bus.flush = 1'b0;
        end
        for (int c = 0; c < 2; c++) begin
            t = 0;
            while (!bus.out_valid && t < 3000) begin @(posedge clk); #2; t++; end
            if (!bus.out_valid) begin
                checks++; failures++;
                $display("FAIL out_valid_timeout ch=%0d actual=0 expected=1", c);
                exp_q.delete();
                return;
            end
            repeat (stall) begin @(posedge clk); #2; end
            bus.out_ready = 1'b1;
            @(posedge clk); #2;
            bus.out_ready = 1'b0;
        end
    endtask

    // Scoreboard: checks every accepted result, hold-stability under backpressure, and RUN latency.
    initial begin
        int          run_cnt;
        bit          stall_prev;
        logic [39:0] held_res;
        logic        held_ch;
        logic        held_ovf;
        exp_t        e;
        run_cnt = 0; stall_prev = 0; held_res = '0; held_ch = 1'b0; held_ovf = 1'b0;
        forever begin
            @(negedge clk);
            if (!clear_n) begin
                run_cnt = 0; stall_prev = 0;
            end else if (bus.out_valid) begin
                if (stall_prev) begin
                    chk("hold_result", bus.result, held_res);
                    chk("hold_out_ch", bus.out_ch, held_ch);
                    chk("hold_coef_ovf", bus.coef_ovf, held_ovf);
                    chk("busy_start_ready", bus.start_ready, 0);
                end
                if (bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_output actual=%h expected=none", bus.result);
                    end else begin
                        e = exp_q.pop_front();
                        chk("result", bus.result, e.res);
                        chk("out_ch", bus.out_ch, e.ch);
                        chk("coef_ovf", bus.coef_ovf, e.ovf);
                        chk("run_cycles", run_cnt, e.lat);
                        got_res[e.ch] = bus.result;
                        got_ovf[e.ch] = bus.coef_ovf;
                    end
                    run_cnt = 0; stall_prev = 0;
                end else begin
                    stall_prev = 1;
                    held_res = bus.result; held_ch = bus.out_ch; held_ovf = bus.coef_ovf;
                end
            end else begin
                stall_prev = 0;
                if (!bus.start_ready) run_cnt++;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.flush = 1'b0; bus.start = 1'b0; bus.sample_ptr = '0; bus.out_ready = 1'b0;
        got_res[0] = '0; got_res[1] = '0; got_ovf[0] = 0; got_ovf[1] = 0;
        clear_cfg();

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_start_ready", bus.start_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_result", bus.result, 0);
        chk("rst_out_ch", bus.out_ch, 0);
        chk("rst_coef_ovf", bus.coef_ovf, 0);
        chk("rst_addrs", {bus.rj_addr, bus.coeff_addr, bus.data_addr}, 0);
        @(posedge clk); #2;
        clear_n = 1'b1;

        // Single add coefficient in group 0
        rj_mem[0] = 8'd1; rj_mem[16] = 8'd1;
        dmem[5] = 16'h4000; dmem[256+5] = 16'h4000;
        run_sample(5, 0, 0, 0);
        chk("lit_add_ch0", got_res[0], 40'h00_0000_4000);
        chk("lit_add_ch1", got_res[1], 40'h00_0000_4000);

        // Single subtract coefficient in the last group
        clear_cfg();
        rj_mem[15] = 8'd1; rj_mem[31] = 8'd1;
        coef_mem[0] = 9'h100; coef_mem[512] = 9'h100;
        dmem[5] = 16'h0001; dmem[256+5] = 16'h0001;
        run_sample(5, 0, 0, 0);
        chk("lit_sub_ch0", got_res[0], 40'hFF_FFFF_8000);
        chk("lit_sub_ch1", got_res[1], 40'hFF_FFFF_8000);

        // Reset in the middle of RUN
        bus.sample_ptr = 8'd5; bus.start = 1'b1;
        @(posedge clk); #2;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        clear_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("midrst_start_ready", bus.start_ready, 1);
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_result", bus.result, 0);
        @(posedge clk); #2;
        clear_n = 1'b1;
        fill_m = 0;
        run_sample(5, 0, 0, 0);
        chk("lit_after_rst", got_res[0], 40'hFF_FFFF_8000);

        // Zero padding of not-yet-received samples
        clear_cfg();
        rj_mem[0] = 8'd1; rj_mem[16] = 8'd1;
        coef_mem[0] = 9'h003; coef_mem[512] = 9'h003;
        dmem[7] = 16'h7FFF; dmem[256+7] = 16'h7FFF;
        run_sample(10, 1, 0, 0);
        chk("lit_pad_n0", got_res[0], 40'h0);
        run_sample(10, 0, 0, 0);
        run_sample(10, 0, 0, 0);
        chk("lit_pad_n2", got_res[1], 40'h0);
        run_sample(10, 0, 0, 0);
        chk("lit_pad_n3", got_res[0], 40'h00_0000_7FFF);

        // Backpressure: result held for 5 cycles
        run_sample(10, 0, 5, 0);
        chk("lit_bp_ch1", got_res[1], 40'h00_0000_7FFF);

        // Mixed groups, empty groups, add/sub, padding; stray start/flush while busy
        clear_cfg();
        for (int i = 0; i < 32; i++)   rj_mem[i]   = 8'(((i % 16) * 3 + i / 16) % 4);
        for (int i = 0; i < 1024; i++) coef_mem[i] = {1'(i % 3 == 1), 8'((i * 7) % 6)};
        for (int i = 0; i < 512; i++)  dmem[i]     = 16'((i * 1237) ^ 32'h5a5a);
        run_sample(200, 1, 2, 1);
        run_sample(201, 0, 0, 1);
        run_sample(2, 0, 1, 0);
        run_sample(255, 0, 0, 1);
        run_sample(0, 0, 3, 0);

        // Rj sum 640 > 512 slots
        for (int i = 0; i < 32; i++) rj_mem[i] = 8'd40;
        run_sample(3, 0, 1, 0);
        chk("lit_ovf_ch0", got_ovf[0], 1);
        chk("lit_ovf_ch1", got_ovf[1], 1);

        repeat (3) @(posedge clk);
        chk("final_queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
